// File: rtl/func_scan_ctrl.sv
// Sweeps a 3-input function block through all eight input codes and captures its truth table.
// Optional SCAN_PARITY_EN adds parity_out, the XOR of all captured table bits.
module func_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  output logic [2:0] w_out,
  output logic       en_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] ones_cnt
`ifdef SCAN_PARITY_EN
  ,
  output logic       parity_out
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] w_q, w_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] table_q, table_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] cnt_q, cnt_d;
  logic       par_q, par_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 8'd0;
      ones_q  <= 4'd0;
      cnt_q   <= 4'd0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          w_d     = 3'd0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          table_d = 8'd0;
          ones_d  = 4'd0;
          cnt_d   = 4'd0;
          par_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // An aborted sample leaves the partial table untouched.
        if (abort) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          table_d[w_q] = f_in;
          ones_d       = ones_q + {3'd0, f_in};
          par_d        = par_q ^ f_in;
          if (w_q != 3'd7) begin
            w_d     = w_q + 3'd1;
            cnt_d   = 4'd0;
            state_d = DRIVE;
          end else begin
            state_d = DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign w_out     = w_q;
  assign en_out    = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign ones_cnt  = ones_q;
`ifdef SCAN_PARITY_EN
  assign parity_out = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_func_scan_ctrl.sv
// Directed bench: SETTLE=1 instance with f_in tied high, SETTLE=2 instance with selectable f_in pattern.
module tb_func_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, abort1, f1;
  logic [2:0] w1;
  logic       en1, busy1, done1;
  logic [7:0] tab1;
  logic [3:0] ones1;
  logic       start2, abort2, f2;
  logic [2:0] w2;
  logic       en2, busy2, done2;
  logic [7:0] tab2;
  logic [3:0] ones2;
  int         mode;
  int         n_chk = 0;
  int         n_pass = 0;
`ifdef SCAN_PARITY_EN
  logic       par1, par2;
`endif

  always #5 clk = ~clk;

  assign f1 = 1'b1;
  always_comb begin
    f2 = 1'b0;
    case (mode)
      0: f2 = (w2 == 3'd2) || (w2 == 3'd6);
      1: f2 = (w2 == 3'd0) || (w2 == 3'd1) || (w2 == 3'd4);
      default: f2 = 1'b1;
    endcase
  end

  func_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f_in(f1),
    .w_out(w1), .en_out(en1), .busy(busy1), .done(done1),
    .table_out(tab1), .ones_cnt(ones1)
`ifdef SCAN_PARITY_EN
    , .parity_out(par1)
`endif
  );

  func_scan_ctrl #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .f_in(f2),
    .w_out(w2), .en_out(en2), .busy(busy2), .done(done2),
    .table_out(tab2), .ones_cnt(ones2)
`ifdef SCAN_PARITY_EN
    , .parity_out(par2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero2(input string tag);
    check({tag, "_w"}, 32'(w2), 0);
    check({tag, "_en"}, 32'(en2), 0);
    check({tag, "_busy"}, 32'(busy2), 0);
    check({tag, "_done"}, 32'(done2), 0);
    check({tag, "_tab"}, 32'(tab2), 0);
    check({tag, "_ones"}, 32'(ones2), 0);
`ifdef SCAN_PARITY_EN
    check({tag, "_par"}, 32'(par2), 0);
`endif
  endtask

  initial begin
    int first;
    int nd;
    int c;
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0; mode = 0;
    #2;
    check_zero2("rst2");
    check("rst1_w", 32'(w1), 0);
    check("rst1_tab", 32'(tab1), 0);
    check("rst1_ones", 32'(ones1), 0);
    tick();
    rst = 1'b0;
    tick();

    // SETTLE=1, f_in tied high: each code held two cycles
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("s1_w_seq", 32'(w1), 32'(k / 2));
      check("s1_en", 32'(en1), 1);
      tick();
    end
    check("s1_done", 32'(done1), 1);
    check("s1_tab", 32'(tab1), 32'hFF);
    check("s1_ones", 32'(ones1), 8);
    check("s1_busy_done", 32'(busy1), 0);
    check("s1_en_done", 32'(en1), 0);
`ifdef SCAN_PARITY_EN
    check("s1_par", 32'(par1), 0);
`endif
    tick();
    check("s1_done_pulse", 32'(done1), 0);
    check("s1_tab_hold", 32'(tab1), 32'hFF);

    // SETTLE=2 scan with a stray start at cycle 5
    mode = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("s2_w0", 32'(w2), 0);
    check("s2_en0", 32'(en2), 1);
    check("s2_busy0", 32'(busy2), 1);
    check("s2_tab0", 32'(tab2), 0);
    first = -1; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) start2 = 1'b1;
      tick();
      start2 = 1'b0;
      if (done2) begin
        nd++;
        if (first < 0) begin
          first = k + 1;
          check("s2_tab", 32'(tab2), 32'h44);
          check("s2_ones", 32'(ones2), 2);
          check("s2_en_done", 32'(en2), 0);
          check("s2_busy_done", 32'(busy2), 0);
`ifdef SCAN_PARITY_EN
          check("s2_par", 32'(par2), 0);
`endif
        end
      end
    end
    check("s2_done_latency", 32'(first), 24);
    check("s2_done_count", 32'(nd), 1);
    check("s2_tab_hold", 32'(tab2), 32'h44);
    check("s2_w_hold", 32'(w2), 7);

    // New scan clears the table, then abort while w_out=4 in DRIVE
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("rs_tab_clr", 32'(tab2), 0);
    check("rs_ones_clr", 32'(ones2), 0);
    check("rs_w", 32'(w2), 0);
    check("rs_en", 32'(en2), 1);
    repeat (12) tick();
    check("ab_w_pre", 32'(w2), 4);
    check("ab_busy_pre", 32'(busy2), 1);
    abort2 = 1'b1; tick(); abort2 = 1'b0;
    check("ab_en", 32'(en2), 0);
    check("ab_busy", 32'(busy2), 0);
    check("ab_tab", 32'(tab2), 32'h04);
    check("ab_ones", 32'(ones2), 1);
    check("ab_w", 32'(w2), 4);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done2) nd++;
    end
    check("ab_no_done", 32'(nd), 0);

    // Asynchronous reset during SAMPLE of code 5
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (17) tick();
    check("ar_w_pre", 32'(w2), 5);
    check("ar_busy_pre", 32'(busy2), 1);
    #2 rst = 1'b1;
    #1;
    check_zero2("ar");
    #1 rst = 1'b0;
    mode = 1;
    tick();
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("ar_restart_w", 32'(w2), 0);
    c = 0;
    while (!done2 && c < 100) begin
      tick();
      c++;
    end
    check("ar_done_latency", 32'(c), 24);
    check("ar_tab", 32'(tab2), 32'h13);
    check("ar_ones", 32'(ones2), 3);
`ifdef SCAN_PARITY_EN
    check("ar_par", 32'(par2), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/func_scan_ctrl.md
FUNC_SCAN_CTRL -- requirements
Module: func_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, range 1..15: DRIVE-state cycles per input code before sampling.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a full scan; honoured only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a scan in progress.
REQ-006 SHALL have port f_in  input  1  output of the 3-input function block under control.
REQ-007 SHALL have port w_out  output  3  code driven to the function block's W input.
REQ-008 SHALL have port en_out  output  1  enable driven to the function block's En input.
REQ-009 SHALL have port busy  output  1  high in DRIVE and SAMPLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on scan completion.
REQ-011 SHALL have port table_out  output  8  captured truth table; bit i = f_in sampled for w_out=i.
REQ-012 SHALL have port ones_cnt  output  4  number of 1 bits in table_out (0..8).

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE, all outputs registered.
REQ-014 IDLE: on a clock edge with start=1, SHALL go to DRIVE with w_out=0, en_out=1, table_out=0, ones_cnt=0, settle counter=0.
REQ-015 DRIVE: SHALL hold w_out/en_out, increment settle counter, and go to SAMPLE at the edge where the counter reaches SETTLE-1.
REQ-016 SAMPLE (one cycle, w_out/en_out still held): at its closing edge SHALL write f_in into table_out[w_out] and add f_in to ones_cnt.
REQ-017 At that same edge, if w_out<7, SHALL increment w_out, clear the counter and return to DRIVE; if w_out=7, SHALL go to DONE.
REQ-018 Each code SHALL be driven for exactly SETTLE+1 cycles; done SHALL be high in the cycle starting 8*(SETTLE+1) edges after the start edge.
REQ-019 DONE: done=1, en_out=0, busy=0 for exactly one cycle, then IDLE; table_out/ones_cnt stable until the next accepted start.
REQ-020 In IDLE, en_out=0 and w_out SHALL hold its last value.
REQ-021 start while busy or in DONE SHALL be ignored; no queuing.
REQ-022 abort=1 in DRIVE or SAMPLE SHALL go to IDLE at that edge: en_out=0, no done pulse, no capture on that edge, table_out/ones_cnt keep partial contents.
REQ-023 abort and start together in IDLE: start wins (abort has no effect in IDLE/DONE).
REQ-024 w_out SHALL never wrap past 7 within a scan.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force IDLE, w_out=0, en_out=0, busy=0, done=0, table_out=0, ones_cnt=0, settle counter=0, parity_out=0 when present.
REQ-026 Reset asserted mid-scan SHALL discard the scan; first start after release SHALL begin a fresh scan from w_out=0.

Configuration
REQ-027 With macro SCAN_PARITY_EN defined, SHALL add output parity_out (1 bit) = XOR of all table_out bits, registered and updated alongside table_out in SAMPLE.
REQ-028 Without SCAN_PARITY_EN, parity_out SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-029 SETTLE=2, bench f_in = (w_out==2 || w_out==6), pulse start -> done high 24 cycles after start edge, table_out=8'b0100_0100, ones_cnt=2, parity_out=0 if enabled.
REQ-030 SETTLE=1, f_in tied 1 -> table_out=8'hFF, ones_cnt=8, done 16 cycles after start; w_out steps 0..7, each held 2 cycles with en_out=1.
REQ-031 start pulsed again at cycle 5 of a scan -> ignored; exactly one done pulse; second start after done -> new scan, table cleared at start edge.
REQ-032 abort asserted while w_out=4 in DRIVE -> IDLE next edge, en_out=0, no done, table_out holds bits 0..3 only.
REQ-033 rst asserted mid-SAMPLE with w_out=5 -> all outputs 0 immediately without waiting for clk; following start gives full correct scan.
REQ-034 SCAN_PARITY_EN defined, f_in = (w_out==0 || w_out==1 || w_out==4) -> table_out=8'b0001_0011, ones_cnt=3, parity_out=1.
